// File: rtl/mem_calc_pkg.sv
// Shared types and default sizing for the calculation result bank.
// Imported by the bank top and its clear sequencer.
package mem_calc_pkg;

    localparam int MC_DATA_W = 16;
    localparam int MC_ADDR_W = 2;
    localparam int MC_FUNC_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/mem_calc_clr_seq.sv
// Clear sequencer: walks the sweep pointer over every entry once per clr.
// busy mirrors the CLEAR state and is registered with it.
module mem_calc_clr_seq
    import mem_calc_pkg::*;
#(
    parameter int ADDR_W = MC_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              busy,
    output logic              idle,
    output logic [ADDR_W-1:0] ptr
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_t state;

    assign idle = (state == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            busy  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (clr) begin
                        state <= CLEAR;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    ptr <= ptr + 1'b1;
                    // Last entry is cleared on this edge, so leave now.
                    if (ptr == ADDR_W'(DEPTH - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mem_calc_bank.sv
// Small result bank: stores function results with their select tag,
// registered write-first read port, valid count and sweeping clear.
module mem_calc_bank
    import mem_calc_pkg::*;
#(
    parameter int DATA_W = MC_DATA_W,
    parameter int ADDR_W = MC_ADDR_W,
    parameter int FUNC_W = MC_FUNC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic [FUNC_W-1:0] sel_func,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              clr,
    output logic [DATA_W-1:0] data_out,
    output logic [FUNC_W-1:0] tag_out,
    output logic              rd_valid,
    output logic              rd_hit,
    output logic              busy,
    output logic [ADDR_W:0]   count,
    output logic              full
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [FUNC_W-1:0] mem_tag  [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [ADDR_W-1:0] ptr;
    logic              idle;
    logic              wr_ok;
    logic              rd_ok;
    logic              fwd;

    mem_calc_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .busy  (busy),
        .idle  (idle),
        .ptr   (ptr)
    );

    assign wr_ok = idle && wr_en && (|sel_func) && !clr;
    assign rd_ok = idle && rd_en && !clr;
    assign fwd   = wr_ok && (wr_addr == rd_addr);
    assign full  = (count == CNT_W'(DEPTH));

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_data[wr_addr] <= data_in;
            mem_tag[wr_addr]  <= sel_func;
        end
        if (busy) begin
            mem_data[ptr] <= '0;
            mem_tag[ptr]  <= '0;
        end
    end

    // Writes and sweeps are mutually exclusive, so one step per edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
            count <= '0;
        end else begin
            if (wr_ok) begin
                valid[wr_addr] <= 1'b1;
                if (!valid[wr_addr]) count <= count + 1'b1;
            end
            if (busy) begin
                valid[ptr] <= 1'b0;
                if (valid[ptr]) count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out <= '0;
            tag_out  <= '0;
            rd_valid <= 1'b0;
            rd_hit   <= 1'b0;
        end else begin
            rd_valid <= rd_ok;
            if (rd_ok) begin
                unique case (1'b1)
                    fwd: begin
                        data_out <= data_in;
                        tag_out  <= sel_func;
                        rd_hit   <= 1'b1;
                    end
                    valid[rd_addr]: begin
                        data_out <= mem_data[rd_addr];
                        tag_out  <= mem_tag[rd_addr];
                        rd_hit   <= 1'b1;
                    end
                    default: begin
                        data_out <= '0;
                        tag_out  <= '0;
                        rd_hit   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_calc_bank.sv
// Scoreboard bench for mem_calc_bank: reads push expectations,
// a negedge monitor pops and compares on every rd_valid pulse.
module tb_mem_calc_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data_in;
    logic [2:0]  sel_func;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic        rd_en;
    logic [1:0]  rd_addr;
    logic        clr;
    logic [15:0] data_out;
    logic [2:0]  tag_out;
    logic        rd_valid;
    logic        rd_hit;
    logic        busy;
    logic [2:0]  count;
    logic        full;

    typedef struct {
        logic [15:0] d;
        logic [2:0]  t;
        logic        h;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_calc_bank dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .sel_func (sel_func),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .clr      (clr),
        .data_out (data_out),
        .tag_out  (tag_out),
        .rd_valid (rd_valid),
        .rd_hit   (rd_hit),
        .busy     (busy),
        .count    (count),
        .full     (full)
    );

    always @(negedge clk) begin
        if (rd_valid) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_rd_valid: got rd_valid=1, required 0");
            end else begin
                exp_t e;
                e = q.pop_front();
                if (data_out !== e.d || tag_out !== e.t || rd_hit !== e.h) begin
                    n_err++;
                    $display("FAIL read: got d=%h t=%0d h=%b, required d=%h t=%0d h=%b",
                             data_out, tag_out, rd_hit, e.d, e.t, e.h);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        wr_en = 0; rd_en = 0; clr = 0;
        data_in = '0; sel_func = '0; wr_addr = '0; rd_addr = '0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d,
                      input logic [2:0] f);
        wr_en = 1; wr_addr = a; data_in = d; sel_func = f;
        cycle();
        idle_in();
    endtask

    task automatic rd(input logic [1:0] a, input logic [15:0] d,
                      input logic [2:0] t, input logic h);
        rd_en = 1; rd_addr = a;
        q.push_back('{d: d, t: t, h: h});
        cycle();
        idle_in();
    endtask

    initial begin
        idle_in();
        rst_n = 0;
        cycle(); cycle();
        rst_n = 1;
        chk("rst_count", 32'(count), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_dout", 32'(data_out), 0);
        chk("rst_rdv", 32'(rd_valid), 0);

        wr(2'd1, 16'h1234, 3'b010);
        rd(2'd1, 16'h1234, 3'b010, 1'b1);
        chk("w1_count", 32'(count), 1);
        cycle();
        chk("rdv_pulse", 32'(rd_valid), 0);

        wr(2'd2, 16'hFFFF, 3'b000);
        rd(2'd2, 16'h0000, 3'b000, 1'b0);
        chk("zero_func_count", 32'(count), 1);

        wr_en = 1; wr_addr = 2'd3; data_in = 16'hBEEF; sel_func = 3'd5;
        rd_en = 1; rd_addr = 2'd3;
        q.push_back('{d: 16'hBEEF, t: 3'd5, h: 1'b1});
        cycle();
        idle_in();
        chk("fwd_count", 32'(count), 2);

        wr_en = 1; wr_addr = 2'd0; data_in = 16'h0A0A; sel_func = 3'd1;
        rd_en = 1; rd_addr = 2'd1;
        q.push_back('{d: 16'h1234, t: 3'b010, h: 1'b1});
        cycle();
        idle_in();
        chk("diff_count", 32'(count), 3);
        rd(2'd0, 16'h0A0A, 3'd1, 1'b1);

        wr(2'd2, 16'h2222, 3'd7);
        chk("fill_count", 32'(count), 4);
        chk("fill_full", 32'(full), 1);
        wr(2'd0, 16'h5555, 3'd3);
        chk("ovw_count", 32'(count), 4);
        chk("ovw_full", 32'(full), 1);
        rd(2'd0, 16'h5555, 3'd3, 1'b1);

        clr = 1;
        cycle();
        idle_in();
        chk("busy_c1", 32'(busy), 1);
        wr_en = 1; wr_addr = 2'd1; data_in = 16'h7777; sel_func = 3'd1;
        rd_en = 1; rd_addr = 2'd0;
        cycle();
        chk("busy_c2", 32'(busy), 1);
        cycle();
        chk("busy_c3", 32'(busy), 1);
        cycle();
        chk("busy_c4", 32'(busy), 1);
        idle_in();
        cycle();
        chk("busy_done", 32'(busy), 0);
        chk("clr_count", 32'(count), 0);
        chk("clr_full", 32'(full), 0);
        for (int i = 0; i < 4; i++) rd(2'(i), 16'h0, 3'd0, 1'b0);

        wr_en = 1; wr_addr = 2'd2; data_in = 16'h3333; sel_func = 3'd2;
        clr = 1;
        cycle();
        idle_in();
        chk("clrwin_count", 32'(count), 0);
        chk("clrwin_busy", 32'(busy), 1);
        cycle(); cycle(); cycle();
        chk("clrwin_busy_end", 32'(busy), 1);
        cycle();
        chk("clrwin_idle", 32'(busy), 0);
        chk("clrwin_count2", 32'(count), 0);
        rd(2'd2, 16'h0, 3'd0, 1'b0);

        wr(2'd1, 16'h0101, 3'd6);
        wr(2'd3, 16'h0303, 3'd6);
        chk("pre_rst_count", 32'(count), 2);
        clr = 1;
        cycle();
        idle_in();
        cycle();
        rst_n = 0;
        cycle();
        rst_n = 1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_rdv", 32'(rd_valid), 0);
        wr(2'd2, 16'h4321, 3'd4);
        rd(2'd2, 16'h4321, 3'd4, 1'b1);
        chk("post_rst_count", 32'(count), 1);
        rd(2'd3, 16'h0, 3'd0, 1'b0);

        cycle(); cycle();
        chk("queue_empty", 32'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_calc_bank.md
MEM_CALC_BANK -- requirements
Module: mem_calc_bank

Interface
REQ-001 The parameter DATA_W SHALL default to 16 and set the stored result width.
REQ-002 The parameter ADDR_W SHALL default to 2 and set the depth as DEPTH = 2**ADDR_W entries.
REQ-003 The parameter FUNC_W SHALL default to 3 and set the function-select tag width.
REQ-004 clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-005 rst_n  in  1  reset; one clock; reset is synchronous and active-low.
REQ-006 data_in  in  DATA_W  result of the performed function.
REQ-007 sel_func  in  FUNC_W  function performed; a value of 0 means no function was performed.
REQ-008 wr_en  in  1  write request.
REQ-009 wr_addr  in  ADDR_W  write entry.
REQ-010 rd_en  in  1  read request.
REQ-011 rd_addr  in  ADDR_W  read entry.
REQ-012 clr  in  1  start-clear request (one-cycle pulse).
REQ-013 data_out  out  DATA_W  registered read data.
REQ-014 tag_out  out  FUNC_W  registered sel_func stored with the read entry.
REQ-015 rd_valid  out  1  one-cycle pulse; data_out and tag_out updated this cycle.
REQ-016 rd_hit  out  1  read entry held valid data, qualified by rd_valid.
REQ-017 busy  out  1  clear sweep in progress.
REQ-018 count  out  ADDR_W+1  number of valid entries, 0..DEPTH.
REQ-019 full  out  1  count == DEPTH, combinational from count.

Function
REQ-020 Each entry SHALL hold the data word, the FUNC_W tag and one valid bit.
REQ-021 A write SHALL be accepted when the state is IDLE, wr_en=1, |sel_func=1 and clr=0; the edge stores data_in and sel_func at wr_addr and sets that entry's valid bit.
REQ-022 wr_en=1 with sel_func=0 SHALL be ignored, with no state change.
REQ-023 An accepted write to an invalid entry SHALL increment count; an overwrite of a valid entry SHALL leave count unchanged.
REQ-024 A read SHALL be accepted when the state is IDLE and rd_en=1 and clr=0; exactly one cycle later rd_valid=1, and data_out, tag_out and rd_hit reflect rd_addr.
REQ-025 A read of an invalid entry SHALL return data_out=0, tag_out=0 and rd_hit=0.
REQ-026 A same-cycle accepted read and write to the same address SHALL be write-first: data_out=data_in, tag_out=sel_func and rd_hit=1.
REQ-027 A same-cycle read and write to different addresses SHALL both complete independently.
REQ-028 data_out and tag_out SHALL hold their values until the next accepted read; rd_valid SHALL be 0 in every other cycle.
REQ-029 The FSM SHALL have the states IDLE and CLEAR.
REQ-030 In IDLE, clr=1 SHALL move the FSM to CLEAR and reset the sweep pointer to 0; busy SHALL be 1 from the next cycle.
REQ-031 In CLEAR, each cycle SHALL clear the valid bit, data and tag at the pointer, decrement count if that entry was valid, and then increment the pointer.
REQ-032 After the entry at DEPTH-1 is cleared, the FSM SHALL return to IDLE: busy is high for exactly DEPTH cycles and count is 0.
REQ-033 While busy=1, wr_en, rd_en and clr SHALL be ignored; no rd_valid pulse SHALL be produced.
REQ-034 When clr coincides with wr_en or rd_en in IDLE, clr SHALL win and the write or read SHALL be dropped.
REQ-035 Addresses SHALL be interpreted modulo DEPTH; no out-of-range address exists.

Reset
REQ-036 While rst_n=0 at a clock edge, the block SHALL set: state IDLE, sweep pointer 0, all valid bits 0, count 0, data_out 0, tag_out 0, rd_valid 0, rd_hit 0, busy 0.
REQ-037 Data and tag storage SHALL NOT require reset; outputs are gated by the valid bits.
REQ-038 A reset asserted mid-sweep SHALL abort the sweep and leave the block in IDLE, with no residual busy.

Structure
REQ-039 A shared package mem_calc_pkg SHALL hold the state enumeration (IDLE, CLEAR) and the default DATA_W, ADDR_W and FUNC_W constants.
REQ-040 The clear sequencer (FSM, sweep pointer, busy) SHALL be one sub-module, mem_calc_clr_seq; storage, the read path and count SHALL stay in mem_calc_bank.

Verification (defaults DATA_W=16, ADDR_W=2)
REQ-041 Write 0x1234 with sel_func=3'b010 at addr 1, then read addr 1 -> next cycle rd_valid=1, data_out=0x1234, tag_out=3'b010, rd_hit=1, count=1.
REQ-042 wr_en=1, sel_func=0, data_in=0xFFFF at addr 2, then read addr 2 -> data_out=0, rd_hit=0, count unchanged.
REQ-043 Same-cycle write 0xBEEF at addr 3 and read addr 3 -> next cycle data_out=0xBEEF, rd_hit=1.
REQ-044 Fill all 4 entries, then overwrite addr 0 -> count=4, full=1; pulse clr -> busy=1 for exactly 4 cycles; a write issued during busy is dropped; afterwards count=0 and every read returns rd_hit=0.
REQ-045 clr and wr_en in the same IDLE cycle -> the write is dropped; count=0 after the sweep.
REQ-046 Assert rst_n=0 at the 2nd cycle of a sweep -> next cycle busy=0, count=0, rd_valid=0; a subsequent write and read operate normally.
